// File: rtl/median_linebuf_sched.sv
// Median line-buffer scheduler: column RMW sequencing, row-valid tracking, window gating; MEDIAN_FLUSH_EN adds bottom-row drain.
// rd->wr latency 1 clken cycle; clken low holds all state and masks strobes; in_valid has no ready (always accepted in RUN).
module median_linebuf_sched #(
  parameter int DATA_W = 9,
  parameter int ROWS   = 10,
  parameter int AW     = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clken,
  input  logic            start,
  input  logic [AW-1:0]   width,
  input  logic [AW-1:0]   height,
  input  logic [1:0]      window_size,
  input  logic            in_valid,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [ROWS-1:0] row_valid,
  output logic            filt_en,
  output logic            zero_inj,
  output logic            busy,
  output logic            frame_done
);

  localparam int RSW = $clog2(ROWS + 1);
  localparam int WORD_W = ROWS * DATA_W;
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  if (ROWS < 3 || WORD_W < ROWS) begin : g_bad_cfg
    $error("median_linebuf_sched: ROWS must be >= 3 and DATA_W >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   width_q, width_d, height_q, height_d;
  logic [RSW-1:0]  p_q, p_d, p_dec;
  logic [AW-1:0]   col_q, col_d, row_q, row_d;
  logic [ROWS-2:0] rv_q, rv_d;
  logic [RSW-1:0]  rows_seen_q, rows_seen_d;
  logic            wr_vld_q, wr_vld_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [ROWS-1:0] row_valid_q, row_valid_d;
  logic            filt_q, filt_d, zinj_q, zinj_d;
  logic            accept, in_drain, col_last;

  always_comb begin
    p_dec = RSW'(2);
    case (window_size)
      2'd0: p_dec = RSW'(2);
      2'd1: p_dec = RSW'(4);
      2'd2: p_dec = RSW'(8);
      default: p_dec = RSW'(10);
    endcase
  end

`ifdef MEDIAN_FLUSH_EN
  logic [AW-1:0] drain_last;
  assign in_drain   = (state_q == S_DRAIN);
  assign drain_last = {{(AW-RSW+1){1'b0}}, p_q[RSW-1:1]} - ONE;
`else
  assign in_drain = 1'b0;
`endif

  assign accept   = clken & (((state_q == S_RUN) & in_valid) | in_drain);
  assign col_last = (col_q == width_q - ONE);

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    p_d         = p_q;
    col_d       = col_q;
    row_d       = row_q;
    rv_d        = rv_q;
    rows_seen_d = rows_seen_q;
    wr_vld_d    = wr_vld_q;
    wr_addr_d   = wr_addr_q;
    row_valid_d = row_valid_q;
    filt_d      = filt_q;
    zinj_d      = zinj_q;

    // Write stage only advances on clken so a held read lines up with its write.
    if (clken) begin
      wr_vld_d = accept;
      filt_d   = accept & (rows_seen_q >= p_q);
      zinj_d   = accept & in_drain;
      if (accept) begin
        wr_addr_d   = col_q;
        row_valid_d = {rv_q, ~in_drain};
      end
    end

    if (accept) begin
      col_d = col_last ? '0 : col_q + ONE;
      if (col_last) begin
        row_d = row_q + ONE;
        rv_d  = {rv_q[ROWS-3:0], ~in_drain};
        if (rows_seen_q != RSW'(ROWS)) rows_seen_d = rows_seen_q + RSW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && clken) begin
          width_d     = width;
          height_d    = height;
          p_d         = p_dec;
          col_d       = '0;
          row_d       = '0;
          rv_d        = '0;
          rows_seen_d = '0;
          row_valid_d = '0;
          state_d     = (width == '0 || height == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && col_last && row_q == height_q - ONE) begin
`ifdef MEDIAN_FLUSH_EN
          state_d = S_DRAIN;
          row_d   = '0;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MEDIAN_FLUSH_EN
      S_DRAIN: begin
        if (accept && col_last && row_q == drain_last) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (clken) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      p_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      rv_q        <= '0;
      rows_seen_q <= '0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= '0;
      row_valid_q <= '0;
      filt_q      <= 1'b0;
      zinj_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      p_q         <= p_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rv_q        <= rv_d;
      rows_seen_q <= rows_seen_d;
      wr_vld_q    <= wr_vld_d;
      wr_addr_q   <= wr_addr_d;
      row_valid_q <= row_valid_d;
      filt_q      <= filt_d;
      zinj_q      <= zinj_d;
    end
  end

  assign rd_en      = accept;
  assign rd_addr    = col_q;
  assign wr_en      = wr_vld_q & clken;
  assign wr_addr    = wr_addr_q;
  assign row_valid  = row_valid_q;
  assign filt_en    = filt_q & clken;
  assign zero_inj   = zinj_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE) & clken;

endmodule

// File: tb/tb_median_linebuf_sched.sv
// Directed bench for median_linebuf_sched: frame sequences, clken gating, mid-frame reset, zero-width frame.
module tb_median_linebuf_sched;
  localparam int ROWS = 10;
  localparam int AW   = 11;

  logic            clk = 1'b0;
  logic            rst, clken, start, in_valid;
  logic [AW-1:0]   width, height;
  logic [1:0]      window_size;
  logic            rd_en, wr_en, filt_en, zero_inj, busy, frame_done;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [ROWS-1:0] row_valid;

  int n_chk = 0;
  int n_fail = 0;

  median_linebuf_sched #(.DATA_W(9), .ROWS(ROWS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clken(clken), .start(start), .width(width),
    .height(height), .window_size(window_size), .in_valid(in_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .row_valid(row_valid), .filt_en(filt_en), .zero_inj(zero_inj),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one frame with in_valid held high and checks every read/write against a row-index model.
  task automatic run_frame(input string tag, input int w, input int h, input int ws,
                           input bit toggle, input int exp_busy);
    logic [AW-1:0] rq[$];
    logic [22:0]   wq[$];
    logic [22:0]   e;
    logic [ROWS-1:0] rv;
    int p, nd, cyc, done_cnt, busy_cnt, viol, lat_err, idx, rs;
    bit pend;
    p = (ws == 0) ? 2 : (ws == 1) ? 4 : (ws == 2) ? 8 : 10;
`ifdef MEDIAN_FLUSH_EN
    nd = p / 2;
`else
    nd = 0;
`endif
    width = 11'(w); height = 11'(h); window_size = 2'(ws);
    start = 1'b1; clken = 1'b1; in_valid = 1'b1;
    cyc = 0; done_cnt = 0; busy_cnt = 0; viol = 0; lat_err = 0; pend = 1'b0;
    while (done_cnt == 0 && cyc < 2000) begin
      @(negedge clk);
      if (rd_en) rq.push_back(rd_addr);
      if (wr_en) wq.push_back({wr_addr, filt_en, zero_inj, row_valid});
      if (busy) busy_cnt++;
      if (frame_done) done_cnt++;
      if (!clken && (rd_en || wr_en || filt_en || frame_done)) viol++;
      if (clken) begin
        if (wr_en !== pend) lat_err++;
        pend = rd_en;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (toggle) clken = ~clken;
    end
    clken = 1'b1;
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    chk({tag, "_clken_gate"}, 64'(viol), 64'd0);
    chk({tag, "_latency"}, 64'(lat_err), 64'd0);
    chk({tag, "_nrd"}, 64'(rq.size()), 64'(w * (h + nd)));
    chk({tag, "_nwr"}, 64'(wq.size()), 64'(w * (h + nd)));
    if (exp_busy >= 0) chk({tag, "_busy"}, 64'(busy_cnt), 64'(exp_busy));
    idx = 0;
    for (int r = 0; r < h + nd; r++) begin
      for (int c = 0; c < w; c++) begin
        for (int k = 0; k < ROWS; k++) rv[k] = (r - k >= 0) && (r - k < h);
        rs = (r < ROWS) ? r : ROWS;
        e = {11'(c), (rs >= p), (r >= h), rv};
        if (idx < rq.size()) chk($sformatf("%s_rd_r%0d_c%0d", tag, r, c), 64'(rq[idx]), 64'(c));
        if (idx < wq.size()) chk($sformatf("%s_wr_r%0d_c%0d", tag, r, c), 64'(wq[idx]), 64'(e));
        idx++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; clken = 1'b1;
    width = 11'd4; height = 11'd3; window_size = 2'd0;
    #1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", 64'({rd_en, wr_en, filt_en, zero_inj, busy, frame_done,
                            row_valid, rd_addr, wr_addr}), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;

    run_frame("f4x3", 4, 3, 0, 1'b0, -1);
    run_frame("f4x3_tog", 4, 3, 0, 1'b1, -1);
    run_frame("f2x12_ws3", 2, 12, 3, 1'b0, -1);

    // Mid-frame reset while reading row 1 col 2.
    width = 11'd4; height = 11'd3; window_size = 2'd0;
    start = 1'b1; clken = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rd", 64'({rd_en, rd_addr, wr_en, wr_addr}), 64'({1'b1, 11'd2, 1'b1, 11'd1}));
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_after_rst", 64'({busy, wr_en, rd_en, filt_en, frame_done, row_valid}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_frame("f4x3_after_rst", 4, 3, 0, 1'b0, -1);

    run_frame("w0", 0, 3, 0, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
